load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage initiator that turns a pipeline load/store request (byte address, funct3, store data) into word-addressed transactions on the data-memory request/grant/rvalid port. It generates byte enables and aligns store data onto byte lanes. It extracts and sign/zero-extends load data. Accesses that straddle a word boundary are split into two word transactions. The block sits between the EX/MEM pipeline register and the data memory, and holds the pipeline via `req_ready` while a transaction is in flight.

## Interface
- `DM_ADDRESS`, 9, word-address width of the data memory.
- `DATA_W`, 32, data width. Fixed at 32; byte-lane logic assumes 4 lanes.
- `ADDR_W`, 32, width of the byte address from the ALU.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: pipeline request present.
- `req_ready` out 1: `(state==IDLE) && !reset`; a request is accepted when `req_valid && req_ready`.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `funct3` in 3: access type.
- `addr` in ADDR_W: byte address. Bits `[DM_ADDRESS+1:0]` are used; upper bits are ignored.
- `wdata` in DATA_W: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `rdata` out DATA_W: extended load result. Holds its value until the next load completes.
- `err` out 1: illegal request. Valid only with `resp_valid`.
- `dm_req` out 1: memory request.
- `dm_we` out 1: write enable.
- `dm_be` out 4: byte enables.
- `dm_addr` out DM_ADDRESS: word address.
- `dm_wdata` out DATA_W: lane-aligned write data.
- `dm_gnt` in 1: memory accepts the request in any cycle where `dm_req && dm_gnt`.
- `dm_rvalid` in 1: read data valid, arriving ≥1 cycle after grant.
- `dm_rdata` in DATA_W: read word.

## Operation
- **Capture on accept:** word address `wa = addr[DM_ADDRESS+1:2]`, offset `off = addr[1:0]`, funct3, and wdata.
- **Size** from `funct3[1:0]`: 00 = byte, 01 = half, 10 = word.
  - Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Legal stores: 000 sb, 001 sh, 010 sw.
- **Illegal requests:** any other funct3, `mem_read == mem_write`, or an illegal store funct3 is accepted, performs no memory access, and completes with `err = 1`. `rdata` is unchanged.
- **Byte enables:** 8-bit mask `m = {0001, 0011, 1111}[size] << off`.
  - Access 0 uses `be = m[3:0]`.
  - If `m[7:4] != 0`, access 1 is issued at `(wa + 1) mod 2^DM_ADDRESS` (wraps to 0) with `be = m[7:4]`.
- **Store data:** `w64 = {32'b0, wdata} << (8*off)`. Access 0 drives `w64[31:0]`; access 1 drives `w64[63:32]`. Lanes whose enable is clear are don't-care.
- **Load data:** `r64 = {rdata1, rdata0} >> (8*off)`, then extend per funct3 (sign for lb/lh, zero for lbu/lhu). `rdata1` is 0 when no split occurs.
- **FSM states:** IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: accept, then go to REQ0. Illegal requests go directly to RESP.
  - REQ0: hold `dm_req = 1` until grant.
    - Load: go to WAIT0.
    - Store: go to REQ1 if split, else RESP.
  - WAIT0: on `dm_rvalid`, capture rdata0, then go to REQ1 if split, else RESP.
  - REQ1 and WAIT1: same as REQ0 and WAIT0, but go to RESP.
  - RESP: `resp_valid = 1`, update `rdata` (loads only), return to IDLE.
- `dm_rvalid` outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `dm_be`, `dm_addr`, `dm_wdata`, `resp_valid`, `rdata`, `err` all 0.
- All `dm_*` outputs and `resp_valid` are registered.
- While `dm_req = 1` and `dm_gnt = 0`, `dm_addr`, `dm_be`, `dm_we`, and `dm_wdata` stay stable.
- `dm_req` deasserts in the cycle after grant unless the next state is REQ1.
- Latency from accept cycle to `resp_valid`, with zero-wait grant and rvalid one cycle after grant:
  - Aligned store: 2 cycles.
  - Aligned load: 3 cycles.
  - Split store: 3 cycles.
  - Split load: 5 cycles.
  - Illegal request: 1 cycle.
- Each grant stall or rvalid delay adds one cycle.
- Reset mid-transaction aborts immediately: `dm_req` drops, no `resp_valid` is issued, and a late `dm_rvalid` is ignored.
- The next request can be accepted in the cycle after RESP.

## Structure
- Package `lsu_pkg` holds:
  - the `lsu_state_e` enum;
  - the `access_size_e` enum (BYTE, HALF, WORD);
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `lsu_align` is purely combinational and computes the byte-enable mask, the 64-bit store shift, and the load extract/extend. The FSM and registers remain in `load_store_unit`.

## Test plan
- **Aligned store:** sw, addr 0x10, wdata 0xDEADBEEF, immediate grant → one `dm_req` with `dm_addr = 4`, `be = 1111`, `dm_we = 1`, `dm_wdata = 0xDEADBEEF`; `resp_valid` 2 cycles after accept; `err = 0`.
- **Byte store:** sb, addr 0x13, wdata 0x000000A5 → `dm_addr = 4`, `be = 1000`, `dm_wdata[31:24] = 0xA5`.
- **Byte loads:** lb, addr 0x06, `dm_rdata = 0x00801234` → `rdata = 0xFFFFFF80`; lbu, same address and data → `rdata = 0x00000080`.
- **Split load:** lw, addr 0x0E; word 3 returns 0xAABBCCDD, word 4 returns 0x11223344 → requests at `dm_addr = 3` (`be = 1100`), then `dm_addr = 4` (`be = 0011`); `rdata = 0x3344AABB`.
- **Wrap and stall:** sw at byte address 0x7FE with `DM_ADDRESS = 9` → word 511 (`be = 1100`), then word 0 (`be = 0011`). Hold `dm_gnt = 0` for 3 cycles → request fields stable and `req_ready = 0` throughout.
- **Illegal request and reset abort:** funct3 = 011 with `mem_read` → no `dm_req`, `resp_valid` with `err = 1`, `rdata` unchanged. Reset asserted in WAIT0 → no `resp_valid`; a following `dm_rvalid` is ignored; `req_ready = 1` after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } access_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A request is legal only if it is exactly one of load/store with a matching funct3.
  function automatic logic req_legal(input logic rd, input logic wr, input logic [2:0] f3);
    logic ld_ok, st_ok;
    ld_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    st_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (rd && !wr && ld_ok) || (wr && !rd && st_ok);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enable mask, store data shift, load extract and extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          funct3,
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata0,
  input  logic [DATA_W-1:0]   rdata1,
  output logic [7:0]          mask,
  output logic [2*DATA_W-1:0] wdata64,
  output logic [DATA_W-1:0]   ldata
);

  logic [3:0]        base;
  logic [DATA_W-1:0] r32;

  // Mask spans two words; the upper nibble is the second access of a split.
  always_comb begin
    base = 4'b0000;
    case (access_size_e'(funct3[1:0]))
      BYTE:    base = 4'b0001;
      HALF:    base = 4'b0011;
      WORD:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    mask    = {4'b0000, base} << off;
    wdata64 = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
  end

  // Shift the (possibly two-word) read down to lane 0, then extend by access type.
  always_comb begin
    r32 = DATA_W'({rdata1, rdata0} >> {off, 3'b000});
    case (funct3)
      F3_B:    ldata = {{24{r32[7]}}, r32[7:0]};
      F3_H:    ldata = {{16{r32[15]}}, r32[15:0]};
      F3_BU:   ldata = {24'b0, r32[7:0]};
      F3_HU:   ldata = {16'b0, r32[15:0]};
      default: ldata = r32;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage initiator: one pipeline request becomes one or two word transactions.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [3:0]            dm_be,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_gnt,
  input  logic                  dm_rvalid,
  input  logic [DATA_W-1:0]     dm_rdata
);

  lsu_state_e state, nxt;

  logic [DM_ADDRESS-1:0] wa_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [DATA_W-1:0]     wdata_q, rdata0_q;
  logic                  load_q, illegal_q;

  logic                  idle, accept, illegal_in, illegal_c, split;
  logic [DM_ADDRESS-1:0] wa_in;
  logic [1:0]            off_c;
  logic [2:0]            f3_c;
  logic [DATA_W-1:0]     wd_c, rd0, rd1, ldata;
  logic [7:0]            mask;
  logic [2*DATA_W-1:0]   w64;
  logic                  unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:DM_ADDRESS+2];

  assign idle       = (state == IDLE);
  assign req_ready  = idle && !reset;
  assign accept     = req_valid && req_ready;
  assign wa_in      = addr[DM_ADDRESS+1:2];
  assign illegal_in = !req_legal(mem_read, mem_write, funct3);

  // While idle the aligner sees the live request so access 0 can be launched on accept.
  assign off_c     = idle ? addr[1:0]  : off_q;
  assign f3_c      = idle ? funct3     : f3_q;
  assign wd_c      = idle ? wdata      : wdata_q;
  assign illegal_c = idle ? illegal_in : illegal_q;

  // Read words are taken straight off the bus in the cycle they arrive.
  assign rd0   = (state == WAIT0) ? dm_rdata : rdata0_q;
  assign rd1   = (state == WAIT1) ? dm_rdata : '0;
  assign split = |mask[7:4];

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3  (f3_c),
    .off     (off_c),
    .wdata   (wd_c),
    .rdata0  (rd0),
    .rdata1  (rd1),
    .mask    (mask),
    .wdata64 (w64),
    .ldata   (ldata)
  );

  // Next-state logic; grant and rvalid each advance by exactly one state.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = illegal_in ? RESP : REQ0;
      REQ0:  if (dm_gnt) nxt = load_q ? WAIT0 : (split ? REQ1 : RESP);
      WAIT0: if (dm_rvalid) nxt = split ? REQ1 : RESP;
      REQ1:  if (dm_gnt) nxt = load_q ? WAIT1 : RESP;
      WAIT1: if (dm_rvalid) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, captured request, and registered bus/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wa_q       <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      load_q     <= 1'b0;
      illegal_q  <= 1'b0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_be      <= '0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= nxt;
      dm_req     <= (nxt == REQ0) || (nxt == REQ1);
      resp_valid <= (nxt == RESP);
      err        <= (nxt == RESP) && illegal_c;

      if (accept) begin
        wa_q      <= wa_in;
        off_q     <= addr[1:0];
        f3_q      <= funct3;
        wdata_q   <= wdata;
        load_q    <= mem_read && !mem_write;
        illegal_q <= illegal_in;
      end

      // Bus fields change only when a new access starts, so they hold through grant stalls.
      if (idle && nxt == REQ0) begin
        dm_addr  <= wa_in;
        dm_be    <= mask[3:0];
        dm_we    <= mem_write && !mem_read;
        dm_wdata <= w64[DATA_W-1:0];
      end else if (state != REQ1 && nxt == REQ1) begin
        dm_addr  <= wa_q + DM_ADDRESS'(1);
        dm_be    <= mask[7:4];
        dm_wdata <= w64[2*DATA_W-1:DATA_W];
      end

      if (state == WAIT0 && dm_rvalid) rdata0_q <= dm_rdata;

      if (nxt == RESP && !idle && load_q) rdata <= ldata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus pushes expected bus accesses and responses, monitors pop and compare.
module tb_load_store_unit;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        resp_valid, err;
  logic [31:0] rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .err(err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] a; logic [3:0] be; logic we; logic [31:0] wd; } dm_t;
  typedef struct { logic err; logic [31:0] rd; int acc; int lat; } rsp_t;

  dm_t         dm_q[$];
  rsp_t        rsp_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:511];
  int          stall_left = 0, rv_delay = 0, rv_cnt = 0;
  logic [8:0]  rv_a;
  dm_t         de;
  rsp_t        re;
  logic [31:0] last_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and bus monitor: drives grant/rvalid and checks each granted access.
  always @(negedge clk) begin
    dm_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem[rv_a];
      end
    end
    dm_gnt = 1'b0;
    if (dm_req) begin
      if (dm_q.size() == 0) chk("dm_req_unexpected", {31'b0, dm_req}, 32'd0);
      else if (stall_left > 0) begin
        stall_left--;
        de = dm_q[0];
        chk("stall_addr", {23'b0, dm_addr}, {23'b0, de.a});
        chk("stall_be", {28'b0, dm_be}, {28'b0, de.be});
        chk("stall_we", {31'b0, dm_we}, {31'b0, de.we});
        if (de.we) chk("stall_wdata", dm_wdata & bmask(de.be), de.wd & bmask(de.be));
        chk("stall_ready", {31'b0, req_ready}, 32'd0);
      end else begin
        dm_gnt = 1'b1;
        de = dm_q.pop_front();
        chk("dm_addr", {23'b0, dm_addr}, {23'b0, de.a});
        chk("dm_be", {28'b0, dm_be}, {28'b0, de.be});
        chk("dm_we", {31'b0, dm_we}, {31'b0, de.we});
        if (de.we) begin
          chk("dm_wdata", dm_wdata & bmask(de.be), de.wd & bmask(de.be));
          for (int b = 0; b < 4; b++)
            if (dm_be[b]) mem[dm_addr][8*b +: 8] = dm_wdata[8*b +: 8];
        end else begin
          rv_cnt = 1 + rv_delay;
          rv_a   = dm_addr;
        end
      end
    end
  end

  // Response monitor: every resp_valid pulse must match the next expected response.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (rsp_q.size() == 0) chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
      else begin
        re = rsp_q.pop_front();
        chk("resp_err", {31'b0, err}, {31'b0, re.err});
        chk("resp_rdata", rdata, re.rd);
        chk("resp_latency", cyc - re.acc, re.lat);
      end
    end
  end

  task automatic exp_dm(input logic [8:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    dm_t e;
    e.a = a; e.be = be; e.we = we; e.wd = wd;
    dm_q.push_back(e);
  endtask

  // Present one request; lat == 0 means no response is expected.
  task automatic send(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input int lat);
    rsp_t r;
    int n;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    if (lat > 0) begin
      r.err = e_err; r.rd = e_rd; r.acc = cyc; r.lat = lat;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || dm_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (rsp_q.size() != 0 || dm_q.size() != 0)
      chk("drain_timeout", rsp_q.size() + dm_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    last_ld = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
    chk("rst_dm_be", {28'b0, dm_be}, 32'd0);
    chk("rst_dm_addr", {23'b0, dm_addr}, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Aligned word store
    exp_dm(9'd4, 4'b1111, 1'b1, 32'hDEADBEEF);
    send(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, last_ld, 2); drain();
    // Byte store into top lane
    exp_dm(9'd4, 4'b1000, 1'b1, 32'hA5000000);
    send(1'b0, 1'b1, F3_B, 32'h13, 32'h000000A5, 1'b0, last_ld, 2); drain();
    // Signed and unsigned byte loads
    mem[1] = 32'h00801234;
    exp_dm(9'd1, 4'b0100, 1'b0, 32'h0);
    last_ld = 32'hFFFFFF80;
    send(1'b1, 1'b0, F3_B, 32'h06, 32'h0, 1'b0, last_ld, 3); drain();
    exp_dm(9'd1, 4'b0100, 1'b0, 32'h0);
    last_ld = 32'h00000080;
    send(1'b1, 1'b0, F3_BU, 32'h06, 32'h0, 1'b0, last_ld, 3); drain();
    // Split word load
    mem[3] = 32'hAABBCCDD; mem[4] = 32'h11223344;
    exp_dm(9'd3, 4'b1100, 1'b0, 32'h0);
    exp_dm(9'd4, 4'b0011, 1'b0, 32'h0);
    last_ld = 32'h3344AABB;
    send(1'b1, 1'b0, F3_W, 32'h0E, 32'h0, 1'b0, last_ld, 5); drain();
    // Illegal requests: bad load funct3, neither read nor write, bad store funct3
    send(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1'b1, last_ld, 1); drain();
    send(1'b0, 1'b0, F3_W, 32'h20, 32'h0, 1'b1, last_ld, 1); drain();
    send(1'b0, 1'b1, F3_BU, 32'h20, 32'h0, 1'b1, last_ld, 1); drain();
    // Wrapping split store with a 3-cycle grant stall on the first access
    stall_left = 3;
    exp_dm(9'd511, 4'b1100, 1'b1, 32'hF00D0000);
    exp_dm(9'd0, 4'b0011, 1'b1, 32'h0000CAFE);
    send(1'b0, 1'b1, F3_W, 32'h7FE, 32'hCAFEF00D, 1'b0, last_ld, 6); drain();
    chk("wrap_mem511", mem[511], 32'hF00D0000);
    chk("wrap_mem0", mem[0], 32'h0000CAFE);
    // Split signed half load
    mem[2] = 32'h000000FF;
    exp_dm(9'd1, 4'b1000, 1'b0, 32'h0);
    exp_dm(9'd2, 4'b0001, 1'b0, 32'h0);
    last_ld = 32'hFFFFFF00;
    send(1'b1, 1'b0, F3_H, 32'h07, 32'h0, 1'b0, last_ld, 5); drain();
    // Delayed rvalid adds cycles
    rv_delay = 2;
    exp_dm(9'd1, 4'b1111, 1'b0, 32'h0);
    last_ld = 32'h00801234;
    send(1'b1, 1'b0, F3_W, 32'h04, 32'h0, 1'b0, last_ld, 5); drain();
    rv_delay = 0;
    // Split half store
    exp_dm(9'd2, 4'b1000, 1'b1, 32'hEF000000);
    exp_dm(9'd3, 4'b0001, 1'b1, 32'h000000BE);
    send(1'b0, 1'b1, F3_H, 32'h0B, 32'h0000BEEF, 1'b0, last_ld, 3); drain();
    chk("sh_mem2", mem[2], 32'hEF0000FF);
    chk("sh_mem3", mem[3], 32'hAABBCCBE);
    // Reset while waiting for read data
    rv_delay = 4;
    exp_dm(9'd8, 4'b1111, 1'b0, 32'h0);
    send(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_dm_req", {31'b0, dm_req}, 32'd0);
    chk("abort_ready_in_rst", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_dm_req_late", {31'b0, dm_req}, 32'd0);
    chk("abort_ready_late", {31'b0, req_ready}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    rv_delay = 0;
    last_ld = 32'h0;
    // Normal operation after abort
    exp_dm(9'd1, 4'b0100, 1'b0, 32'h0);
    last_ld = 32'h00000080;
    send(1'b1, 1'b0, F3_BU, 32'h06, 32'h0, 1'b0, last_ld, 3); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
